// File: rtl/muldiv_pkg.sv
// Shared types and default control codes for the multi-cycle mult/div sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic {MUL, DIV} kind_t;

  localparam int DEF_CTRL_MULT = 10;
  localparam int DEF_CTRL_DIV  = 11;
  // Signed variants sit this far above their unsigned codes
  localparam int SIGNED_OFFSET = 2;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between pipeline control (master) and the mult/div sequencer (slave).
interface muldiv_sequencer_if #(
  parameter int WIDTH      = 32,
  parameter int CTRL_WIDTH = 4
);

  logic                  start;
  logic [CTRL_WIDTH-1:0] control;
  logic [WIDTH-1:0]      op_a;
  logic [WIDTH-1:0]      op_b;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic                  div_by_zero;
  logic [WIDTH-1:0]      hi;
  logic [WIDTH-1:0]      lo;

  modport master (
    output start, control, op_a, op_b, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, control, op_a, op_b, flush,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_datapath.sv
// Iterative shift-add multiplier / restoring divider with sign fix-up and
// divide-by-zero result forcing; sequenced by load/step from muldiv_sequencer.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  kind_t            kind_in,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  kind_t            kind;
  logic [WIDTH-1:0] upper;
  logic [WIDTH-1:0] lower;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] a_raw;
  logic             neg_hi;
  logic             neg_lo;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   upper_next;
  logic [WIDTH-1:0]   lower_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  always_comb begin
    mag_a = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
    mag_b = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;
  end

  // Divide uses the borrow of (shifted - divisor) as the compare; since rem < divisor
  // is held every iteration, a clear borrow guarantees the difference fits in WIDTH bits.
  always_comb begin
    add_sum    = {1'b0, upper} + {1'b0, (lower[0] ? operand : '0)};
    shifted    = {upper, lower[WIDTH-1]};
    diff       = shifted - {1'b0, operand};
    upper_next = upper;
    lower_next = lower;
    if (kind == MUL) begin
      upper_next = add_sum[WIDTH:1];
      lower_next = {add_sum[0], lower[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      upper_next = diff[WIDTH-1:0];
      lower_next = {lower[WIDTH-2:0], 1'b1};
    end else begin
      upper_next = shifted[WIDTH-1:0];
      lower_next = {lower[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    prod     = {upper, lower};
    fin_hi   = upper;
    fin_lo   = lower;
    div_zero = (kind == DIV) && (operand == '0);
    if (kind == MUL) begin
      if (neg_lo) prod = -prod;
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end else begin
      if (neg_hi) fin_hi = -upper;
      if (neg_lo) fin_lo = -lower;
    end
    res_hi = div_zero ? a_raw : fin_hi;
    res_lo = div_zero ? '1    : fin_lo;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kind    <= MUL;
      upper   <= '0;
      lower   <= '0;
      operand <= '0;
      a_raw   <= '0;
      neg_hi  <= 1'b0;
      neg_lo  <= 1'b0;
    end else if (load) begin
      kind    <= kind_in;
      a_raw   <= op_a;
      neg_hi  <= signed_op & op_a[WIDTH-1];
      neg_lo  <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      upper   <= '0;
      if (kind_in == MUL) begin
        operand <= mag_a;
        lower   <= mag_b;
      end else begin
        operand <= mag_b;
        lower   <= mag_a;
      end
    end else if (step) begin
      upper <= upper_next;
      lower <= lower_next;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle mult/div sequencer: IDLE/RUN/DONE control, HI/LO and div_by_zero registers.
// Define MULDIV_SIGNED_EN to also accept the signed codes CTRL_MULT+2 / CTRL_DIV+2.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CTRL_WIDTH = 4,
  parameter int CTRL_MULT  = DEF_CTRL_MULT,
  parameter int CTRL_DIV   = DEF_CTRL_DIV
) (
  input logic               clk,
  input logic               rst_n,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             dbz_q;

  logic             accept;
  logic             step;
  logic             commit;
  logic             valid_code;
  kind_t            kind_sel;
  logic             signed_sel;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             div_zero;

  // RUN spends WIDTH cycles iterating and one more cycle committing the settled result
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    commit     = 1'b0;
    valid_code = 1'b0;
    kind_sel   = MUL;
    signed_sel = 1'b0;

    if (bus.control == CTRL_WIDTH'(CTRL_MULT)) begin
      valid_code = 1'b1;
      kind_sel   = MUL;
    end else if (bus.control == CTRL_WIDTH'(CTRL_DIV)) begin
      valid_code = 1'b1;
      kind_sel   = DIV;
    end
`ifdef MULDIV_SIGNED_EN
    else if (bus.control == CTRL_WIDTH'(CTRL_MULT + SIGNED_OFFSET)) begin
      valid_code = 1'b1;
      kind_sel   = MUL;
      signed_sel = 1'b1;
    end else if (bus.control == CTRL_WIDTH'(CTRL_DIV + SIGNED_OFFSET)) begin
      valid_code = 1'b1;
      kind_sel   = DIV;
      signed_sel = 1'b1;
    end
`endif

    case (state)
      IDLE: begin
        if (bus.start && !bus.flush && valid_code) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else if (count == CW'(WIDTH)) begin
          commit     = 1'b1;
          state_next = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      dbz_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        count <= '0;
        dbz_q <= 1'b0;
      end else if (step) begin
        count <= count + 1'b1;
      end
      if (commit) begin
        hi_q  <= res_hi;
        lo_q  <= res_lo;
        dbz_q <= div_zero;
      end
    end
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .step      (step),
    .kind_in   (kind_sel),
    .signed_op (signed_sel),
    .op_a      (bus.op_a),
    .op_b      (bus.op_b),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .div_zero  (div_zero)
  );

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: timing, results, flush, ignore rules, reset.
module tb_muldiv_sequencer;

  localparam int WIDTH = 32;
  localparam int CTRLW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   fails  = 0;

  muldiv_sequencer_if #(.WIDTH(WIDTH), .CTRL_WIDTH(CTRLW)) bus ();

  muldiv_sequencer #(
    .WIDTH      (WIDTH),
    .CTRL_WIDTH (CTRLW),
    .CTRL_MULT  (10),
    .CTRL_DIV   (11)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    bus.start   = 1'b1;
    bus.control = ctrl;
    bus.op_a    = a;
    bus.op_b    = b;
    tick();
    bus.start   = 1'b0;
    bus.control = 4'd0;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.control = 4'd0; bus.op_a = '0; bus.op_b = '0;
    tick(); tick();
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy actual=%b required=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done actual=%b required=0", bus.done); end
    checks++; if (bus.div_by_zero !== 1'b0) begin fails++; $display("[TB] FAIL reset_dbz actual=%b required=0", bus.div_by_zero); end
    checks++; if (bus.hi !== 32'h0) begin fails++; $display("[TB] FAIL reset_hi actual=%h required=0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin fails++; $display("[TB] FAIL reset_lo actual=%h required=0", bus.lo); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    int done_at = -1;
    int busy_cnt = 0;
    int done_cnt = 0;
    start_op(4'd10, 32'hFFFF_FFFF, 32'h0000_0002);
    for (int k = 0; k < 60; k++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      tick();
    end
    checks++; if (done_at != 33) begin fails++; $display("[TB] FAIL mult_done_latency actual=%0d required=33", done_at); end
    checks++; if (busy_cnt != 34) begin fails++; $display("[TB] FAIL mult_busy_cycles actual=%0d required=34", busy_cnt); end
    checks++; if (done_cnt != 1) begin fails++; $display("[TB] FAIL mult_done_pulses actual=%0d required=1", done_cnt); end
    checks++; if (bus.hi !== 32'h0000_0001) begin fails++; $display("[TB] FAIL mult_hi actual=%h required=00000001", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFFE) begin fails++; $display("[TB] FAIL mult_lo actual=%h required=fffffffe", bus.lo); end
  endtask

  task automatic test_div();
    bit seen;
    start_op(4'd11, 32'd100, 32'd7);
    wait_done(100, seen);
    checks++; if (!seen) begin fails++; $display("[TB] FAIL div_done_timeout actual=none required=done within 100 cycles"); end
    checks++; if (bus.lo !== 32'd14) begin fails++; $display("[TB] FAIL div_quot actual=%0d required=14", bus.lo); end
    checks++; if (bus.hi !== 32'd2) begin fails++; $display("[TB] FAIL div_rem actual=%0d required=2", bus.hi); end
    checks++; if (bus.div_by_zero !== 1'b0) begin fails++; $display("[TB] FAIL div_dbz actual=%b required=0", bus.div_by_zero); end
    tick();
  endtask

  task automatic test_div_zero();
    bit seen;
    start_op(4'd11, 32'h0000_1234, 32'h0);
    wait_done(100, seen);
    checks++; if (!seen) begin fails++; $display("[TB] FAIL dbz_done_timeout actual=none required=done within 100 cycles"); end
    checks++; if (bus.hi !== 32'h0000_1234) begin fails++; $display("[TB] FAIL dbz_hi actual=%h required=00001234", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL dbz_lo actual=%h required=ffffffff", bus.lo); end
    checks++; if (bus.div_by_zero !== 1'b1) begin fails++; $display("[TB] FAIL dbz_flag actual=%b required=1", bus.div_by_zero); end
    tick();
    checks++; if (bus.div_by_zero !== 1'b1) begin fails++; $display("[TB] FAIL dbz_sticky actual=%b required=1", bus.div_by_zero); end
    start_op(4'd10, 32'd6, 32'd7);
    checks++; if (bus.div_by_zero !== 1'b0) begin fails++; $display("[TB] FAIL dbz_clear_on_start actual=%b required=0", bus.div_by_zero); end
    wait_done(100, seen);
    checks++; if (!seen) begin fails++; $display("[TB] FAIL mult42_done_timeout actual=none required=done within 100 cycles"); end
    checks++; if (bus.lo !== 32'd42 || bus.hi !== 32'd0) begin fails++; $display("[TB] FAIL mult42_result actual=%h_%h required=00000000_0000002a", bus.hi, bus.lo); end
    tick();
  endtask

  task automatic test_flush();
    bit seen;
    int done_cnt = 0;
    start_op(4'd10, 32'd3, 32'd5);
    for (int k = 0; k < 10; k++) begin
      if (bus.done) done_cnt++;
      tick();
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL flush_busy actual=%b required=0", bus.busy); end
    for (int k = 0; k < 40; k++) begin
      if (bus.done) done_cnt++;
      tick();
    end
    checks++; if (done_cnt != 0) begin fails++; $display("[TB] FAIL flush_no_done actual=%0d required=0", done_cnt); end
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd42) begin fails++; $display("[TB] FAIL flush_hold actual=%h_%h required=00000000_0000002a", bus.hi, bus.lo); end
    start_op(4'd10, 32'd9, 32'd9);
    checks++; if (bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL flush_restart_busy actual=%b required=1", bus.busy); end
    wait_done(100, seen);
    checks++; if (!seen) begin fails++; $display("[TB] FAIL flush_restart_timeout actual=none required=done within 100 cycles"); end
    checks++; if (bus.lo !== 32'd81) begin fails++; $display("[TB] FAIL flush_restart_lo actual=%0d required=81", bus.lo); end
    tick();
  endtask

  task automatic test_ignored();
    start_op(4'd5, 32'd1, 32'd1);
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL ignore_code5 actual=%b required=0", bus.busy); end
`ifndef MULDIV_SIGNED_EN
    start_op(4'd12, 32'd1, 32'd1);
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL ignore_code12 actual=%b required=0", bus.busy); end
`endif
    bus.flush = 1'b1;
    start_op(4'd10, 32'd2, 32'd2);
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL flush_beats_start actual=%b required=0", bus.busy); end
    checks++; if (bus.lo !== 32'd81) begin fails++; $display("[TB] FAIL ignore_hold_lo actual=%0d required=81", bus.lo); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    start_op(4'd10, 32'h0001_0000, 32'h0001_0000);
    bus.start = 1'b1; bus.control = 4'd11; bus.op_a = 32'd1; bus.op_b = 32'd1;
    wait_done(100, seen);
    checks++; if (!seen) begin fails++; $display("[TB] FAIL busy_start_timeout actual=none required=done within 100 cycles"); end
    checks++; if (bus.hi !== 32'd1 || bus.lo !== 32'd0) begin fails++; $display("[TB] FAIL busy_start_result actual=%h_%h required=00000001_00000000", bus.hi, bus.lo); end
    tick();
    bus.start = 1'b0; bus.control = 4'd0;
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL start_in_done actual=%b required=0", bus.busy); end
  endtask

  task automatic test_reset_run();
    start_op(4'd10, 32'd3, 32'd5);
    for (int k = 0; k < 5; k++) tick();
    rst_n = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_run_busy actual=%b required=0", bus.busy); end
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin fails++; $display("[TB] FAIL rst_run_hilo actual=%h_%h required=00000000_00000000", bus.hi, bus.lo); end
    rst_n = 1'b1;
    tick();
  endtask

`ifdef MULDIV_SIGNED_EN
  task automatic test_signed();
    bit seen;
    start_op(4'd12, 32'hFFFF_FFFD, 32'd5);
    wait_done(100, seen);
    checks++; if (!seen) begin fails++; $display("[TB] FAIL smult_timeout actual=none required=done within 100 cycles"); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFF1) begin fails++; $display("[TB] FAIL smult_result actual=%h_%h required=ffffffff_fffffff1", bus.hi, bus.lo); end
    tick();
    start_op(4'd13, 32'hFFFF_FFF9, 32'd2);
    wait_done(100, seen);
    checks++; if (!seen) begin fails++; $display("[TB] FAIL sdiv_timeout actual=none required=done within 100 cycles"); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin fails++; $display("[TB] FAIL sdiv_result actual=%h_%h required=ffffffff_fffffffd", bus.hi, bus.lo); end
    tick();
    start_op(4'd13, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(100, seen);
    checks++; if (!seen) begin fails++; $display("[TB] FAIL sdiv_minneg_timeout actual=none required=done within 100 cycles"); end
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h8000_0000) begin fails++; $display("[TB] FAIL sdiv_minneg actual=%h_%h required=00000000_80000000", bus.hi, bus.lo); end
    tick();
  endtask
`endif

  initial begin
    $display("[TB] muldiv_sequencer directed test start");
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_flush();
    test_ignored();
    test_back_to_back();
    test_reset_run();
`ifdef MULDIV_SIGNED_EN
    test_signed();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
